// File: rtl/ft245_pkg.sv
// Shared types and counter widths for the FT245 synchronous FIFO bridge.
// The state encoding is used by the bridge FSM; widths size the burst and flush counters.
package ft245_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RX_OE    = 2'd1,
    ST_RX_READ  = 2'd2,
    ST_TX_WRITE = 2'd3
  } state_t;

  localparam int BURST_W = 8;
  localparam int FLUSH_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; a full FIFO ignores push even when popped.
// rdata is the current head and is valid whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ft245_sync_bridge.sv
// FT232H 245-synchronous FIFO bridge: buffers user bytes both ways and arbitrates the shared USB bus.
// state       | meaning
// ST_IDLE     | bus released, round-robin choice between RX and TX service
// ST_RX_OE    | FT232H takes the bus; one turnaround cycle before reading
// ST_RX_READ  | rd_n strobes while data, buffer space and burst budget remain
// ST_TX_WRITE | bridge drives the bus; wr_n strobes while space, data and budget remain
module ft245_sync_bridge
  import ft245_pkg::*;
#(
  parameter int TX_DEPTH      = 512,
  parameter int RX_DEPTH      = 512,
  parameter int BURST_MAX     = 64,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [7:0]                  usb_din,
  output logic [7:0]                  usb_dout,
  output logic                        usb_doe,
  input  logic                        rxf_n,
  input  logic                        txe_n,
  output logic                        rd_n,
  output logic                        wr_n,
  output logic                        oe_n,
  output logic                        siwu,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);
  localparam logic [FLUSH_W-1:0] FLUSH_LIM = FLUSH_W'(FLUSH_TIMEOUT);
  localparam bit                 FLUSH_EN  = (FLUSH_TIMEOUT != 0);

  state_t             state;
  logic               rr_tx;
  logic [BURST_W-1:0] burst_cnt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               flush_pend;

  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_head;
  logic       burst_ok, rx_go, tx_go, rx_req, tx_req, flush_hit;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (tx_data),
    .push  (tx_valid),
    .pop   (tx_go),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (usb_din),
    .push  (rx_go),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign tx_ready = ~tx_full & ~rst;
  assign rx_valid = ~rx_empty;

  assign burst_ok = (burst_cnt < BURST_LIM);
  assign rx_req   = ~rxf_n & ~rx_full;
  assign tx_req   = ~txe_n & ~tx_empty;
  assign rx_go    = (state == ST_RX_READ) & rx_req & burst_ok;
  assign tx_go    = (state == ST_TX_WRITE) & tx_req & burst_ok;

  assign rd_n     = ~rx_go;
  assign wr_n     = ~tx_go;
  assign oe_n     = ~((state == ST_RX_OE) || (state == ST_RX_READ));
  assign usb_doe  = (state == ST_TX_WRITE);
  assign usb_dout = usb_doe ? tx_head : 8'h00;

  // rr_tx remembers which side to favour next time both request in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_tx     <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_req && (!tx_req || !rr_tx)) begin
            state     <= ST_RX_OE;
            rr_tx     <= 1'b1;
            burst_cnt <= '0;
          end else if (tx_req) begin
            state     <= ST_TX_WRITE;
            rr_tx     <= 1'b0;
            burst_cnt <= '0;
          end
        end
        ST_RX_OE: state <= ST_RX_READ;
        ST_RX_READ: begin
          if (rx_go) burst_cnt <= burst_cnt + 1'b1;
          else       state     <= ST_IDLE;
        end
        ST_TX_WRITE: begin
          if (tx_go) burst_cnt <= burst_cnt + 1'b1;
          else       state     <= ST_TX_WRITE == state ? ST_IDLE : state;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign flush_hit = FLUSH_EN && (flush_cnt == FLUSH_LIM);
  assign siwu      = ~flush_hit;

  always_ff @(posedge clk) begin
    if (rst || flush_hit) begin
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (tx_go) flush_pend <= 1'b1;
      if ((state == ST_IDLE) && tx_empty && flush_pend) flush_cnt <= flush_cnt + 1'b1;
      else                                              flush_cnt <= '0;
    end
  end

endmodule
